// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode constants,
// opcode classes, FSM state encoding and PC source selection.
package instruction_sequencer_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned PCSRC_W  = 2;
    localparam int unsigned COUNT_W  = 16;

    // Opcodes with architectural meaning; everything above OP_HLT is undefined.
    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'h01;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_SLL  = 6'h06;
    localparam logic [OPCODE_W-1:0] OP_SRL  = 6'h07;
    localparam logic [OPCODE_W-1:0] OP_SLT  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'h09;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'h0B;
    localparam logic [OPCODE_W-1:0] OP_SUBI = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'h10;
    localparam logic [OPCODE_W-1:0] OP_XORI = 6'h11;
    localparam logic [OPCODE_W-1:0] OP_SLLI = 6'h12;
    localparam logic [OPCODE_W-1:0] OP_SRLI = 6'h13;
    localparam logic [OPCODE_W-1:0] OP_LUI  = 6'h14;
    localparam logic [OPCODE_W-1:0] OP_IN   = 6'h15;
    localparam logic [OPCODE_W-1:0] OP_OUT  = 6'h16;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 6'h17;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 6'h18;
    localparam logic [OPCODE_W-1:0] OP_HLT  = 6'h19;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_BEQ,
        CLS_BNE,
        CLS_IMM,
        CLS_LW,
        CLS_SW,
        CLS_IN,
        CLS_OUT,
        CLS_JMP,
        CLS_NOP,
        CLS_HLT,
        CLS_ILLEGAL
    } op_class_t;

    // Encoding 3'd7 is intentionally unused and recovers to ST_FETCH.
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_WAIT_IN = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    typedef enum logic [PCSRC_W-1:0] {
        PC_SRC_INC    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_t;

endpackage

// File: rtl/instruction_sequencer_opcode_classifier.sv
// Combinational opcode -> instruction class decode.
// Ports: opcode (in, 6) raw opcode from IR; op_class (out) decoded class.
module opcode_classifier
    import instruction_sequencer_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SLL, OP_SRL, OP_SLT:           op_class = CLS_ALU;
            OP_BEQ:                                   op_class = CLS_BEQ;
            OP_BNE:                                   op_class = CLS_BNE;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI,
            OP_XORI, OP_SLLI, OP_SRLI, OP_LUI:        op_class = CLS_IMM;
            OP_LW:                                    op_class = CLS_LW;
            OP_SW:                                    op_class = CLS_SW;
            OP_IN:                                    op_class = CLS_IN;
            OP_OUT:                                   op_class = CLS_OUT;
            OP_JMP:                                   op_class = CLS_JMP;
            OP_NOP:                                   op_class = CLS_NOP;
            OP_HLT:                                   op_class = CLS_HLT;
            default:                                  op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM
// with input-wait and halt states, sticky illegal-opcode flag and a
// saturating retired-instruction counter.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   opcode, alu_zero           IR opcode, ALU zero flag (EXEC)
//   in_valid, mem_ready        input word available, data memory done
//   seq_irWrite .. seq_inAck   per-cycle control strobes (decoded from state)
//   seq_pcSrc                  PC source select
//   seq_hlt, seq_illegal       halted, sticky undefined-opcode flag
//   seq_state, instr_count     current state, retired-instruction count
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    // Value loaded into instr_count by reset.
    parameter logic [COUNT_W-1:0] COUNT_RESET = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                in_valid,
    input  logic                mem_ready,
    output logic                seq_irWrite,
    output logic                seq_pcWrite,
    output logic [PCSRC_W-1:0]  seq_pcSrc,
    output logic                seq_regWrite,
    output logic                seq_memRead,
    output logic                seq_memWrite,
    output logic                seq_inAck,
    output logic                seq_hlt,
    output logic                seq_illegal,
    output logic [STATE_W-1:0]  seq_state,
    output logic [COUNT_W-1:0]  instr_count
);

    state_t       state;
    op_class_t    cls;
    op_class_t    dec_cls;
    logic         illegal;
    logic [COUNT_W-1:0] count;

    logic         ir_write;
    logic         pc_write;
    pc_src_t      pc_src;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         in_ack;
    logic         br_taken;

    opcode_classifier u_classifier (
        .opcode   (opcode),
        .op_class (dec_cls)
    );

    assign br_taken = ((cls == CLS_BEQ) && alu_zero) || ((cls == CLS_BNE) && !alu_zero);

    // Strobe decode; DECODE uses the live class since the register loads at its end.
    // Holding reset forces every strobe low so an aborted access never writes.
    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_INC;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        in_ack    = 1'b0;
        if (!reset) begin
            case (state)
                ST_FETCH: ir_write = 1'b1;
                ST_DECODE: begin
                    case (dec_cls)
                        CLS_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_JUMP;
                        end
                        CLS_NOP, CLS_ILLEGAL: pc_write = 1'b1;
                        default: ;
                    endcase
                end
                ST_EXEC: begin
                    if ((cls == CLS_BEQ) || (cls == CLS_BNE)) begin
                        pc_write = 1'b1;
                        pc_src   = br_taken ? PC_SRC_BRANCH : PC_SRC_INC;
                    end
                end
                ST_MEM: begin
                    mem_read  = (cls == CLS_LW);
                    mem_write = (cls == CLS_SW);
                    pc_write  = (cls == CLS_SW) && mem_ready;
                end
                ST_WB: begin
                    reg_write = (cls != CLS_OUT);
                    pc_write  = 1'b1;
                end
                ST_WAIT_IN: begin
                    reg_write = in_valid;
                    in_ack    = in_valid;
                    pc_write  = in_valid;
                end
                default: ;
            endcase
        end
    end

    // State, latched class, sticky illegal flag and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_FETCH;
            cls     <= CLS_NOP;
            illegal <= 1'b0;
            count   <= COUNT_RESET;
        end else begin
            if (pc_write && (count != {COUNT_W{1'b1}})) begin
                count <= count + COUNT_W'(1);
            end
            case (state)
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    cls <= dec_cls;
                    if (dec_cls == CLS_ILLEGAL) begin
                        illegal <= 1'b1;
                    end
                    case (dec_cls)
                        CLS_JMP, CLS_NOP, CLS_ILLEGAL: state <= ST_FETCH;
                        CLS_HLT:                       state <= ST_HALT;
                        CLS_IN:                        state <= ST_WAIT_IN;
                        default:                       state <= ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    case (cls)
                        CLS_BEQ, CLS_BNE: state <= ST_FETCH;
                        CLS_LW, CLS_SW:   state <= ST_MEM;
                        default:          state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state <= (cls == CLS_SW) ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB: state <= ST_FETCH;
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign seq_irWrite  = ir_write;
    assign seq_pcWrite  = pc_write;
    assign seq_pcSrc    = pc_src;
    assign seq_regWrite = reg_write;
    assign seq_memRead  = mem_read;
    assign seq_memWrite = mem_write;
    assign seq_inAck    = in_ack;
    assign seq_hlt      = (state == ST_HALT);
    assign seq_illegal  = illegal;
    assign seq_state    = state;
    assign instr_count  = count;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer. A second instance with the
// counter preloaded near its ceiling tracks saturation on the same stimulus.
module tb_instruction_sequencer;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        alu_zero;
    logic        in_valid;
    logic        mem_ready;

    logic        ir_w, pc_w, rg_w, m_rd, m_wr, in_ack, hlt, ill;
    logic [1:0]  pc_src;
    logic [2:0]  st;
    logic [15:0] cnt;

    logic        s_ir_w, s_pc_w, s_rg_w, s_m_rd, s_m_wr, s_in_ack, s_hlt, s_ill;
    logic [1:0]  s_pc_src;
    logic [2:0]  s_st;
    logic [15:0] s_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    // Strobe vector layout: [7]ir [6]pcWrite [5:4]pcSrc [3]regWrite [2]memRead [1]memWrite [0]inAck
    localparam logic [7:0] S_NONE = 8'b0000_0000;
    localparam logic [7:0] S_IR   = 8'b1000_0000;
    localparam logic [7:0] S_PC0  = 8'b0100_0000;
    localparam logic [7:0] S_PCBR = 8'b0101_0000;
    localparam logic [7:0] S_PCJ  = 8'b0110_0000;
    localparam logic [7:0] S_RW   = 8'b0000_1000;
    localparam logic [7:0] S_MR   = 8'b0000_0100;
    localparam logic [7:0] S_MW   = 8'b0000_0010;
    localparam logic [7:0] S_ACK  = 8'b0000_0001;

    instruction_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .in_valid(in_valid), .mem_ready(mem_ready),
        .seq_irWrite(ir_w), .seq_pcWrite(pc_w), .seq_pcSrc(pc_src),
        .seq_regWrite(rg_w), .seq_memRead(m_rd), .seq_memWrite(m_wr),
        .seq_inAck(in_ack), .seq_hlt(hlt), .seq_illegal(ill),
        .seq_state(st), .instr_count(cnt)
    );

    instruction_sequencer #(.COUNT_RESET(16'hFFFC)) dut_sat (
        .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
        .in_valid(in_valid), .mem_ready(mem_ready),
        .seq_irWrite(s_ir_w), .seq_pcWrite(s_pc_w), .seq_pcSrc(s_pc_src),
        .seq_regWrite(s_rg_w), .seq_memRead(s_m_rd), .seq_memWrite(s_m_wr),
        .seq_inAck(s_in_ack), .seq_hlt(s_hlt), .seq_illegal(s_ill),
        .seq_state(s_st), .instr_count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_strobes(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, ir_w, pc_w, pc_src, rg_w, m_rd, m_wr, in_ack}, {24'd0, exp});
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, st}, {29'd0, exp});
    endtask

    task automatic chk_counts(input string tag);
        int sat;
        sat = 32'hFFFC + exp_cnt;
        if (sat > 32'hFFFF) sat = 32'hFFFF;
        chk({tag, "_count"}, {16'd0, cnt}, exp_cnt);
        chk({tag, "_count_sat"}, {16'd0, s_cnt}, sat);
    endtask

    // Starts in a FETCH cycle; ends in the following FETCH cycle.
    task automatic do_wb(input logic [5:0] op, input logic [7:0] wb_exp, input string tag);
        opcode = op;
        settle();
        chk_strobes({tag, "_fetch"}, S_IR);
        cyc();
        chk_state({tag, "_decode_st"}, 3'd1);
        chk_strobes({tag, "_decode"}, S_NONE);
        cyc();
        chk_state({tag, "_exec_st"}, 3'd2);
        cyc();
        chk_state({tag, "_wb_st"}, 3'd4);
        chk_strobes({tag, "_wb"}, wb_exp);
        exp_cnt++;
        cyc();
        chk_state({tag, "_next_st"}, 3'd0);
        chk_counts(tag);
    endtask

    task automatic do_branch(input logic [5:0] op, input logic z, input logic [7:0] ex_exp, input string tag);
        opcode   = op;
        alu_zero = ~z;
        cyc();
        chk_strobes({tag, "_decode"}, S_NONE);
        cyc();
        alu_zero = z;
        settle();
        chk_state({tag, "_exec_st"}, 3'd2);
        chk_strobes({tag, "_exec"}, ex_exp);
        exp_cnt++;
        cyc();
        chk_state({tag, "_next_st"}, 3'd0);
        chk_counts(tag);
    endtask

    task automatic do_short(input logic [5:0] op, input logic [7:0] dec_exp, input string tag);
        opcode = op;
        cyc();
        settle();
        chk_state({tag, "_decode_st"}, 3'd1);
        chk_strobes({tag, "_decode"}, dec_exp);
        exp_cnt++;
        cyc();
        chk_state({tag, "_next_st"}, 3'd0);
        chk_counts(tag);
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; alu_zero = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        cyc();
        cyc();
        chk_strobes("rst_strobes", S_NONE);
        chk_state("rst_state", 3'd0);
        chk_counts("rst");
        chk("rst_illegal", {31'd0, ill}, 32'd0);
        chk("rst_hlt", {31'd0, hlt}, 32'd0);
        reset = 1'b0;
        settle();
        chk_strobes("first_fetch", S_IR);

        do_wb(6'h00, S_PC0 | S_RW, "alu");
        do_branch(6'h09, 1'b1, S_PCBR, "beq_taken");
        do_branch(6'h09, 1'b0, S_PC0,  "beq_not");
        do_branch(6'h0A, 1'b0, S_PCBR, "bne_taken");
        do_branch(6'h0A, 1'b1, S_PC0,  "bne_not");

        // LW with three not-ready cycles; early mem_ready/in_valid are ignored
        opcode = 6'h0F;
        cyc();
        mem_ready = 1'b1;
        cyc();
        settle();
        chk_state("lw_exec_st", 3'd2);
        chk_strobes("lw_exec", S_NONE);
        cyc();
        mem_ready = 1'b0;
        in_valid  = 1'b1;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk_state("lw_mem_wait_st", 3'd3);
            chk_strobes("lw_mem_wait", S_MR);
            cyc();
        end
        mem_ready = 1'b1;
        settle();
        chk_strobes("lw_mem_done", S_MR);
        cyc();
        mem_ready = 1'b0;
        in_valid  = 1'b0;
        settle();
        chk_state("lw_wb_st", 3'd4);
        chk_strobes("lw_wb", S_PC0 | S_RW);
        exp_cnt++;
        cyc();
        chk_state("lw_next_st", 3'd0);
        chk_counts("lw");

        // SW completing immediately
        opcode = 6'h10;
        cyc();
        cyc();
        chk_strobes("sw_exec", S_NONE);
        cyc();
        mem_ready = 1'b1;
        settle();
        chk_strobes("sw_mem", S_MW | S_PC0);
        exp_cnt++;
        cyc();
        mem_ready = 1'b0;
        chk_state("sw_next_st", 3'd0);
        chk_counts("sw");

        do_wb(6'h16, S_PC0, "out");
        do_wb(6'h11, S_PC0 | S_RW, "imm");

        // IN with five idle WAIT_IN cycles
        opcode = 6'h15;
        cyc();
        in_valid = 1'b1;
        settle();
        chk_strobes("in_decode", S_NONE);
        cyc();
        in_valid = 1'b0;
        settle();
        for (int i = 0; i < 5; i++) begin
            chk_state("in_wait_st", 3'd5);
            chk_strobes("in_wait", S_NONE);
            cyc();
        end
        in_valid = 1'b1;
        settle();
        chk_strobes("in_ack", S_RW | S_ACK | S_PC0);
        exp_cnt++;
        cyc();
        chk_state("in_next_st", 3'd0);
        chk_strobes("in_next", S_IR);
        in_valid = 1'b0;
        chk_counts("in");

        do_short(6'h17, S_PCJ, "jmp");
        do_short(6'h18, S_PC0, "nop");
        chk("pre_illegal", {31'd0, ill}, 32'd0);
        do_short(6'h2A, S_PC0, "illegal");
        chk("illegal_set", {31'd0, ill}, 32'd1);
        do_short(6'h18, S_PC0, "nop2");
        chk("illegal_sticky", {31'd0, ill}, 32'd1);

        // Reset during an SW memory access
        opcode = 6'h10;
        cyc();
        cyc();
        cyc();
        settle();
        chk_strobes("abort_mem", S_MW);
        reset = 1'b1;
        settle();
        chk_strobes("abort_rst", S_NONE);
        cyc();
        exp_cnt = 0;
        chk_state("abort_st", 3'd0);
        chk("abort_illegal", {31'd0, ill}, 32'd0);
        chk_counts("abort");
        reset = 1'b0;
        settle();
        chk_strobes("abort_fetch", S_IR);

        // HLT holds for 20 cycles with every input active
        opcode = 6'h19;
        cyc();
        chk_state("hlt_decode_st", 3'd1);
        cyc();
        in_valid = 1'b1; mem_ready = 1'b1; alu_zero = 1'b1;
        settle();
        for (int i = 0; i < 20; i++) begin
            chk("hlt_flag", {31'd0, hlt}, 32'd1);
            chk_state("hlt_st", 3'd6);
            chk_strobes("hlt_strobes", S_NONE);
            chk_counts("hlt");
            cyc();
        end
        reset = 1'b1;
        cyc();
        chk_state("hlt_rst_st", 3'd0);
        chk("hlt_rst_flag", {31'd0, hlt}, 32'd0);
        chk_counts("hlt_rst");
        reset = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
        settle();
        chk_strobes("hlt_rst_fetch", S_IR);

        do_wb(6'h00, S_PC0 | S_RW, "alu2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 opcode  in  6  instruction opcode from IR; valid from DECODE onward.
REQ-004 alu_zero  in  1  ALU zero flag, sampled in EXEC.
REQ-005 in_valid  in  1  user input word available (level).
REQ-006 mem_ready  in  1  data memory completes current access (level).
REQ-007 seq_irWrite  out  1  load IR from instruction memory.
REQ-008 seq_pcWrite  out  1  update PC this cycle.
REQ-009 seq_pcSrc  out  2  PC source: 0 PC+1, 1 branch target, 2 jump target.
REQ-010 seq_regWrite  out  1  register file write strobe.
REQ-011 seq_memRead / seq_memWrite  out  1 each  data memory strobes.
REQ-012 seq_inAck  out  1  consume input word.
REQ-013 seq_hlt  out  1  processor halted.
REQ-014 seq_illegal  out  1  sticky: undefined opcode decoded.
REQ-015 seq_state  out  3  current state encoding.
REQ-016 instr_count  out  16  retired-instruction counter.

Function
REQ-017 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, WAIT_IN=5, HALT=6; 7 unreachable, recovers to FETCH next cycle.
REQ-018 Opcode classes SHALL be: ALU 0x00-0x08; BEQ 0x09; BNE 0x0A; IMM 0x0B-0x0E, 0x11-0x14; LW 0x0F; SW 0x10; IN 0x15; OUT 0x16; JMP 0x17; NOP 0x18; HLT 0x19; ILLEGAL 0x1A-0x3F.
REQ-019 FETCH: seq_irWrite=1 for exactly one cycle, then DECODE.
REQ-020 DECODE: class SHALL be registered; JMP -> pcWrite=1, pcSrc=2, FETCH; NOP/ILLEGAL -> pcWrite=1, pcSrc=0, FETCH (ILLEGAL sets seq_illegal); HLT -> HALT; IN -> WAIT_IN; others -> EXEC.
REQ-021 EXEC: BEQ/BNE -> pcWrite=1, pcSrc=1 if (BEQ&alu_zero)|(BNE&~alu_zero) else 0, then FETCH; LW/SW -> MEM; ALU/IMM/OUT -> WB.
REQ-022 MEM: seq_memRead (LW) or seq_memWrite (SW) held high every cycle until mem_ready=1; on that cycle SW -> pcWrite=1, pcSrc=0, FETCH; LW -> WB.
REQ-023 WB: seq_regWrite=1 except OUT; pcWrite=1, pcSrc=0; then FETCH.
REQ-024 WAIT_IN: stay while in_valid=0; cycle in_valid=1 asserts seq_regWrite, seq_inAck, pcWrite (pcSrc=0) together, then FETCH.
REQ-025 HALT: seq_hlt=1, all strobes 0, remains until reset.
REQ-026 Strobes SHALL be combinational from registered state, registered class and current alu_zero/mem_ready/in_valid; all default 0.
REQ-027 instr_count SHALL increment on every cycle seq_pcWrite=1, saturating at 0xFFFF; HLT not counted.
REQ-028 Latencies (no waits): JMP/NOP 2, branch 3, ALU/IMM/OUT 4, SW 4, LW 5, IN 3 cycles; each wait cycle adds one.
REQ-029 in_valid outside WAIT_IN and mem_ready outside MEM SHALL be ignored.
REQ-030 At most one of seq_memRead, seq_memWrite, seq_irWrite high in any cycle.

Reset
REQ-031 reset=1 SHALL on next edge set state=FETCH, class=NOP, instr_count=0, seq_illegal=0, seq_hlt=0.
REQ-032 During reset all strobes SHALL be 0; reset mid-MEM or mid-WAIT_IN aborts access with no write.
REQ-033 First seq_irWrite SHALL occur in the first cycle after reset deasserts.

Structure
REQ-034 Shared package SHALL hold opcode constants 0x00-0x19, class enum, state encoding, pcSrc encoding.
REQ-035 One sub-module opcode_classifier (combinational opcode -> class) SHALL be used; sequencer FSM and counter in top.

Verification
REQ-036 Reset, then opcode 0x00 -> irWrite cycle 1, regWrite+pcWrite in cycle 4, instr_count=1.
REQ-037 opcode 0x09, alu_zero=1 -> pcSrc=1 in EXEC; repeat alu_zero=0 -> pcSrc=0; 0x0A inverse.
REQ-038 opcode 0x0F, mem_ready low 3 cycles -> memRead high 4 cycles, WB regWrite at cycle 8.
REQ-039 opcode 0x15, in_valid after 5 cycles -> inAck+regWrite single cycle, state=FETCH next.
REQ-040 opcode 0x19 -> seq_hlt=1 held 20 cycles, count frozen; reset -> FETCH, count=0.
REQ-041 opcode 0x2A -> seq_illegal=1, pcSrc=0, count+1; 0xFFFF retires -> count stays 0xFFFF.
